// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// Imported by the loader top and its byte packer.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    CHECK,
    RUN,
    ERR
  } loader_state_e;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port.
// master = stream source / memory side, slave = loader.
interface imem_loader_if #(
  parameter int AW = 8
);
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader_packer.sv
// Packs accepted bytes into little-endian 32-bit words.
// word/word_valid are combinational on the 4th byte of each word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);
  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  lane;
  logic [23:0] sh;

  assign word_valid = in_valid && (lane == LAST);
  assign word       = {in_data, sh};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane <= '0;
      sh   <= '0;
    end else if (clr) begin
      lane <= '0;
      sh   <= '0;
    end else if (in_valid) begin
      lane <= lane + 2'd1;
      sh   <= {in_data, sh[23:8]};
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a checksummed image into imem,
// then releases the core from hold.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic  clk,
  input  logic  reset,
  imem_loader_if.slave bus,
  input  logic  reload,
  output logic  cpu_hold,
  output logic  done,
  output logic  error
);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  loader_state_e state;
  logic [AW:0]   widx;
  logic [AW:0]   nwords;
  logic [31:0]   acc;
  logic          accept;
  logic          rearm;
  logic          pk_valid;
  logic [31:0]   pk_word;
  logic          count_ok;

  assign accept   = bus.byte_valid && bus.byte_ready;
  assign rearm    = reload && (state == RUN || state == ERR);
  assign count_ok = (pk_word != 32'd0) && (pk_word <= 32'(DEPTH));

  byte_packer u_pk (
    .clk        (clk),
    .reset      (reset),
    .clr        (rearm),
    .in_valid   (accept),
    .in_data    (bus.byte_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= HDR;
      widx           <= '0;
      nwords         <= '0;
      acc            <= '0;
      bus.byte_ready <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_hold       <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        HDR: begin
          bus.byte_ready <= 1'b1;
          if (pk_valid) begin
            if (count_ok) begin
              state  <= LOAD;
              nwords <= pk_word[AW:0];
            end else begin
              state          <= ERR;
              error          <= 1'b1;
              bus.byte_ready <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (pk_valid) begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= widx[AW-1:0];
            bus.imem_wdata <= pk_word;
            acc            <= acc ^ pk_word;
            widx           <= widx + ONE;
            if (widx == nwords - ONE) state <= CHECK;
          end
        end
        CHECK: begin
          if (pk_valid) begin
            bus.byte_ready <= 1'b0;
            if (pk_word == acc) begin
              state    <= RUN;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        RUN, ERR: begin
          // Re-arm: core goes back into hold on this same edge
          if (reload) begin
            state          <= HDR;
            bus.byte_ready <= 1'b1;
            cpu_hold       <= 1'b1;
            error          <= 1'b0;
            widx           <= '0;
            nwords         <= '0;
            acc            <= '0;
          end
        end
        default: state <= HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed images plus
// random words/stalls checked against a stream-level model.
module tb_imem_loader;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reload = 1'b0;
  logic cpu_hold, done, error;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .reload   (reload),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int nassert = 0;
  int nfail = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [31:0] mem [DEPTH];

  always @(negedge clk) begin
    if (bus.imem_we) begin
      mem[bus.imem_addr] = bus.imem_wdata;
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  function automatic logic [31:0] xor_all(input logic [31:0] w[$]);
    logic [31:0] x = 32'd0;
    foreach (w[i]) x ^= w[i];
    return x;
  endfunction

  // Sends header/words/checksum and checks every cycle's
  // outputs against what the stream rules say must happen.
  task automatic run_image(input logic [31:0] n, input logic [31:0] w[$],
                           input logic [31:0] cs, input int maxgap);
    logic [7:0] s[$];
    bit ok, pass, wend;
    int nw, k, wr0, gap;
    nw = w.size();
    ok = (n != 0) && (n <= DEPTH);
    for (int b = 0; b < 4; b++) s.push_back(n[8*b +: 8]);
    if (ok) begin
      foreach (w[i])
        for (int b = 0; b < 4; b++) s.push_back(w[i][8*b +: 8]);
      for (int b = 0; b < 4; b++) s.push_back(cs[8*b +: 8]);
    end
    pass = ok && (xor_all(w) == cs);
    for (int c = 0; c < 4 && bus.byte_ready !== 1'b1; c++) tick();
    check("ready_start", bus.byte_ready, 1);
    wr0 = wr_cnt;
    for (int i = 0; i < s.size(); i++) begin
      gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      for (int g = 0; g < gap; g++) begin
        bus.byte_data = 8'($urandom);
        reload = 1'($urandom_range(0, 1));
        tick();
        check("gap_we", bus.imem_we, 0);
      end
      reload = 1'b0;
      check("ready", bus.byte_ready, 1);
      put_byte(s[i]);
      k = i - 4;
      wend = ok && k >= 0 && k < 4*nw && (k % 4) == 3;
      check("we", bus.imem_we, wend);
      if (wend) begin
        check("addr", bus.imem_addr, k / 4);
        check("wdata", bus.imem_wdata, w[k/4]);
      end
      if (i == s.size() - 1) begin
        check("done_end", done, pass);
        check("err_end", error, !pass);
        check("hold_end", cpu_hold, !pass);
        check("ready_end", bus.byte_ready, 0);
      end else begin
        check("done_mid", done, 0);
        check("err_mid", error, 0);
        check("hold_mid", cpu_hold, 1);
      end
    end
    tick();
    check("done_fall", done, 0);
    check("err_hold", error, !pass);
    tick();
    check("wr_count", wr_cnt - wr0, ok ? nw : 0);
  endtask

  task automatic do_reload(input bit from_run);
    check("pre_hold", cpu_hold, from_run ? 0 : 1);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("rl_hold", cpu_hold, 1);
    check("rl_ready", bus.byte_ready, 1);
    check("rl_err", error, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wq[$];
    logic [31:0] img[$];
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    #12;
    check("rst_ready", bus.byte_ready, 0);
    check("rst_we", bus.imem_we, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_wdata", bus.imem_wdata, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    tick();
    reset = 1'b1;
    check("ready_pre_edge", bus.byte_ready, 0);
    tick();
    check("ready_rise", bus.byte_ready, 1);

    wq = {32'hE3A00005, 32'hE2800001};
    run_image(2, wq, 32'h01200004, 0);
    check("nom_done_cnt", done_cnt, 1);
    check("nom_mem0", mem[0], 32'hE3A00005);
    check("nom_mem1", mem[1], 32'hE2800001);
    do_reload(1);

    wq = {};
    run_image(0, wq, 32'd0, 0);
    do_reload(0);
    run_image(DEPTH + 1, wq, 32'd0, 0);
    do_reload(0);

    wq = {32'h12345678};
    run_image(1, wq, 32'h12345679, 0);
    check("bad_cs_mem0", mem[0], 32'h12345678);
    do_reload(0);

    wq = {};
    for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
    run_image(DEPTH, wq, xor_all(wq), 5);
    for (int i = 0; i < DEPTH; i++) check("stall_mem", mem[i], wq[i]);
    check("stall_done_cnt", done_cnt, 2);
    do_reload(1);

    img = {};
    for (int i = 0; i < 8; i++) img.push_back($urandom);
    put_byte(8'd8); put_byte(8'd0); put_byte(8'd0); put_byte(8'd0);
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 4; b++) put_byte(img[i][8*b +: 8]);
    check("pre_rst_we", bus.imem_we, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_ready", bus.byte_ready, 0);
    check("mid_rst_we", bus.imem_we, 0);
    check("mid_rst_addr", bus.imem_addr, 0);
    check("mid_rst_wdata", bus.imem_wdata, 0);
    check("mid_rst_hold", cpu_hold, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", error, 0);
    tick();
    reset = 1'b1;
    run_image(8, img, xor_all(img), 2);
    for (int i = 0; i < 8; i++) check("rst_reload_mem", mem[i], img[i]);
    check("rst_done_cnt", done_cnt, 3);

    do_reload(1);
    wq = {};
    for (int i = 0; i < 5; i++) wq.push_back(~img[i] ^ $urandom);
    run_image(5, wq, xor_all(wq), 1);
    for (int i = 0; i < 5; i++) check("rl_new_mem", mem[i], wq[i]);
    check("rl_keep_mem5", mem[5], img[5]);
    check("rl_done_cnt", done_cnt, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end
endmodule
